// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   state_t    - responder FSM states (IDLE / WAIT / RESP)
//   DMEM_DW    - data width of this release (32 bits)
//   STRB_W     - byte-strobe width (DMEM_DW / 8)
//   addr_err() - request address check (misaligned or beyond DEPTH words)
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DMEM_DW = 32;
   localparam int STRB_W  = DMEM_DW / 8;

   // Address is passed zero-extended to 64 bits so one function serves any AW.
   // A request is rejected when it is not word aligned or its word index is
   // beyond the storage depth.
   function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[63:2]} >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-organised storage with a synchronous byte-enable write port and a
// registered read port. No reset: contents are undefined after power-up and
// are never touched by the responder reset.
// Ports:
//   clk      in   clock
//   i_wr     in   write enable (strobed lanes of word i_idx)
//   i_rd     in   read enable (o_rdata <= word i_idx)
//   i_idx    in   word index
//   i_wdata  in   write data
//   i_wstrb  in   byte-lane write enables, lane i -> i_wdata[8i+7:8i]
//   o_rdata  out  registered read data (holds until the next read)
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 1024,
   parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            i_wr,
   input  logic            i_rd,
   input  logic [IW-1:0]   i_idx,
   input  logic [DW-1:0]   i_wdata,
   input  logic [DW/8-1:0] i_wstrb,
   output logic [DW-1:0]   o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_wr) begin
         for (int i = 0; i < DW/8; i++) begin
            if (i_wstrb[i]) begin
               r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
      if (i_rd) begin
         r_rdata <= r_mem[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with a fixed request-to-response
// latency. Holds the FSM, latency counter, request capture registers and the
// error check; storage lives in dmem_array.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE (and not in the cycle reset releases);
// rsp_valid stays 1 with rsp_rdata/rsp_err stable until rsp_ready is sampled 1.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_wstrb  in   store byte-lane enables
//   rsp_valid  out  response present
//   rsp_ready  in   response accepted
//   rsp_rdata  out  load data (0 for stores and errors)
//   rsp_err    out  request rejected
//   dbg_state  out  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   input  logic [DW/8-1:0] req_wstrb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic [1:0]      dbg_state
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              r_live;
   logic              r_we;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [DW/8-1:0]   r_wstrb;
   logic              r_err;
   logic              r_load_ok;

   logic              w_accept;
   logic              w_op_we;
   logic [AW-1:0]     w_op_addr;
   logic [DW-1:0]     w_op_wdata;
   logic [DW/8-1:0]   w_op_wstrb;
   logic              w_op_err;
   logic              w_enter_resp;
   logic              w_arr_wr;
   logic              w_arr_rd;
   logic [DW-1:0]     w_arr_rdata;

   // r_live keeps req_ready low until the first edge after reset releases.
   assign req_ready = r_live && (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   // With LATENCY = 1 the array is accessed on the acceptance edge itself,
   // before the capture registers are loaded, so the live request is used.
   assign w_op_we    = (r_state == IDLE) ? req_we    : r_we;
   assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
   assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_op_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;
   assign w_op_err   = addr_err(64'(w_op_addr), 64'(DEPTH));

   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
   assign w_arr_wr     = w_enter_resp && w_op_we && !w_op_err;
   assign w_arr_rd     = w_enter_resp && !w_op_we && !w_op_err;

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_next = RESP;
               end else begin
                  w_next    = WAIT;
                  w_cnt_nxt = 4'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next = RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_live    <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_err     <= 1'b0;
         r_load_ok <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_live  <= 1'b1;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
         end
         if (w_enter_resp) begin
            r_err     <= w_op_err;
            r_load_ok <= !w_op_we && !w_op_err;
         end
      end
   end

   dmem_array #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk     (clk),
      .i_wr    (w_arr_wr),
      .i_rd    (w_arr_rd),
      .i_idx   (w_op_addr[IW+1:2]),
      .i_wdata (w_op_wdata),
      .i_wstrb (w_op_wstrb),
      .o_rdata (w_arr_rdata)
   );

   // Array output only reaches rsp_rdata for a good load; this also keeps the
   // (unreset) array register from showing through during reset.
   assign rsp_valid = (r_state == RESP);
   assign rsp_err   = rsp_valid && r_err;
   assign rsp_rdata = (rsp_valid && r_load_ok) ? w_arr_rdata : '0;
   assign dbg_state = r_state;

endmodule
